// File: rtl/mgt_01_div_unit_pkg.sv
// Shared definitions for the multi-cycle integer divider: op encodings,
// FSM state encoding and the iteration count.
package mgt_01_div_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DIV_ITER = 32;

    typedef logic [XLEN-1:0] data_u;

    localparam data_u INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        MUL_U    = 2'd0,
        MULH_U   = 2'd1,
        MULHSU_U = 2'd2,
        MULHU_U  = 2'd3
    } mul_ops_e;

    typedef enum logic [1:0] {
        DIV_U  = 2'd0,
        DIVU_U = 2'd1,
        REM_U  = 2'd2,
        REMU_U = 2'd3
    } div_ops_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREPARE = 3'd1,
        DIVIDE  = 3'd2,
        RESTORE = 3'd3,
        DONE    = 3'd4
    } div_fsm_e;

endpackage

// File: rtl/mgt_01_div_unit_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, emit one quotient bit.
module mgt_01_div_step
    import mgt_01_div_unit_pkg::*;
(
    input  data_u rem_i,
    input  data_u quot_i,
    input  data_u dvs_i,
    output data_u rem_o,
    output data_u quot_o
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            qbit;
    logic            diff_unused;

    assign rem_sh = {rem_i, quot_i[XLEN-1]};
    // Extra top bit is the borrow; a set borrow means the divisor did not fit.
    assign diff   = {1'b0, rem_sh} - {2'b00, dvs_i};
    assign qbit   = ~diff[XLEN+1];

    // When the subtraction succeeds the difference is below the divisor, so bit XLEN is zero.
    assign diff_unused = diff[XLEN];

    assign rem_o  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quot_o = {quot_i[XLEN-2:0], qbit};

endmodule

// File: rtl/mgt_01_div_unit.sv
// Multi-cycle signed/unsigned divider (quotient or remainder), one quotient
// bit per enabled cycle, with stall, flush and zero/overflow short-cuts.
module mgt_01_div_unit
    import mgt_01_div_unit_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     clk_en_i,
    input  logic     kill_i,
    input  logic     valid_i,
    input  data_u    op_A_i,
    input  data_u    op_B_i,
    input  div_ops_e ops_i,
    output data_u    result_o,
    output logic     valid_o,
    output logic     busy_o
);

    div_fsm_e   state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    div_ops_e   op_q, op_d;
    data_u      quot_q, quot_d;
    data_u      rem_q, rem_d;
    data_u      dvs_q, dvs_d;
    logic       q_neg_q, q_neg_d;
    logic       r_neg_q, r_neg_d;
    data_u      result_q, result_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    data_u      step_rem, step_quot;
    logic       is_signed;

    mgt_01_div_step u_step (
        .rem_i  (rem_q),
        .quot_i (quot_q),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .quot_o (step_quot)
    );

    assign is_signed = (op_q == DIV_U) || (op_q == REM_U);

    // quot_q holds the dividend on entry and is shifted into the quotient during DIVIDE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;

        if (kill_i) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (valid_i) begin
                    op_d    = ops_i;
                    quot_d  = op_A_i;
                    dvs_d   = op_B_i;
                    busy_d  = 1'b1;
                    state_d = PREPARE;
                end
                PREPARE: begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    q_neg_d = 1'b0;
                    r_neg_d = 1'b0;
                    if (dvs_q == '0) begin
                        quot_d  = '1;
                        rem_d   = quot_q;
                        state_d = DONE;
                    end else if (is_signed && quot_q == INT_MIN && dvs_q == '1) begin
                        quot_d  = INT_MIN;
                        state_d = DONE;
                    end else begin
                        quot_d  = (is_signed && quot_q[XLEN-1]) ? -quot_q : quot_q;
                        dvs_d   = (is_signed && dvs_q[XLEN-1])  ? -dvs_q  : dvs_q;
                        q_neg_d = is_signed && (quot_q[XLEN-1] ^ dvs_q[XLEN-1]);
                        r_neg_d = is_signed && quot_q[XLEN-1];
                        state_d = DIVIDE;
                    end
                end
                DIVIDE: begin
                    quot_d = step_quot;
                    rem_d  = step_rem;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_ITER - 1)) state_d = RESTORE;
                end
                RESTORE: begin
                    if (q_neg_q) quot_d = -quot_q;
                    if (r_neg_q) rem_d  = -rem_q;
                    state_d = DONE;
                end
                DONE: begin
                    result_d = (op_q == DIV_U || op_q == DIVU_U) ? quot_q : rem_q;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= DIV_U;
            quot_q   <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign result_o = result_q;
    assign valid_o  = valid_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_mgt_01_div_unit.sv
// Directed self-checking bench for mgt_01_div_unit.
module tb_mgt_01_div_unit;
    import mgt_01_div_unit_pkg::*;

    logic     clk_i, rst_n_i, clk_en_i, kill_i, valid_i;
    data_u    op_A_i, op_B_i, result_o;
    div_ops_e ops_i;
    logic     valid_o, busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        div_ops_e op;
        data_u    a;
        data_u    b;
        data_u    exp;
    } vec_t;

    vec_t nvec[11];
    vec_t svec[6];

    mgt_01_div_unit dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clk_en_i (clk_en_i),
        .kill_i   (kill_i),
        .valid_i  (valid_i),
        .op_A_i   (op_A_i),
        .op_B_i   (op_B_i),
        .ops_i    (ops_i),
        .result_o (result_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Drives one request (accept edge E0) and returns the number of enabled
    // edges after E0 at which valid_o was seen, or -1 on timeout.
    task automatic run_op(input div_ops_e op, input data_u a, input data_u b,
                          output data_u res, output int lat);
        ops_i = op; op_A_i = a; op_B_i = b; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk_i); #1;
            if (valid_o) begin
                lat = k;
                res = result_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; clk_en_i = 1'b1; kill_i = 1'b0; valid_i = 1'b0;
        op_A_i = '0; op_B_i = '0; ops_i = DIV_U;
        #12;
        tests_run++;
        if (result_o !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 00000000", result_o); end
        tests_run++;
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        @(negedge clk_i); rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        tests_run++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL idle_after_reset: busy %b valid %b want 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_normal();
        data_u res; int lat;
        nvec[0]  = '{DIV_U,  32'd100,        32'd7,          32'd14};
        nvec[1]  = '{REM_U,  32'd100,        32'd7,          32'd2};
        nvec[2]  = '{DIV_U,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2};
        nvec[3]  = '{REM_U,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE};
        nvec[4]  = '{DIVU_U, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF};
        nvec[5]  = '{REMU_U, 32'hFFFFFFFF,   32'd2,          32'd1};
        nvec[6]  = '{DIV_U,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2};
        nvec[7]  = '{REM_U,  32'd100,        32'hFFFFFFF9,   32'd2};
        nvec[8]  = '{DIV_U,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14};
        nvec[9]  = '{REMU_U, 32'd1000,       32'd33,         32'd10};
        nvec[10] = '{DIVU_U, 32'h80000000,   32'd3,          32'h2AAAAAAA};
        for (int i = 0; i < 11; i++) begin
            run_op(nvec[i].op, nvec[i].a, nvec[i].b, res, lat);
            tests_run++;
            if (res !== nvec[i].exp) begin tests_failed++; $display("FAIL normal_result[%0d]: got %h want %h", i, res, nvec[i].exp); end
            tests_run++;
            if (lat !== 35) begin tests_failed++; $display("FAIL normal_latency[%0d]: got %0d want 35", i, lat); end
        end
    endtask

    task automatic test_special();
        data_u res; int lat;
        svec[0] = '{DIVU_U, 32'd5,        32'd0,        32'hFFFFFFFF};
        svec[1] = '{REMU_U, 32'd5,        32'd0,        32'd5};
        svec[2] = '{DIV_U,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
        svec[3] = '{REM_U,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};
        svec[4] = '{DIV_U,  32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        svec[5] = '{REM_U,  32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 6; i++) begin
            run_op(svec[i].op, svec[i].a, svec[i].b, res, lat);
            tests_run++;
            if (res !== svec[i].exp) begin tests_failed++; $display("FAIL special_result[%0d]: got %h want %h", i, res, svec[i].exp); end
            tests_run++;
            if (lat !== 2) begin tests_failed++; $display("FAIL special_latency[%0d]: got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        data_u res; int lat;
        run_op(DIVU_U, 32'd1000, 32'd33, res, lat);
        tests_run++;
        if (res !== 32'd30 || lat !== 35) begin tests_failed++; $display("FAIL b2b_first: got %h lat %0d want 0000001e lat 35", res, lat); end
        run_op(REMU_U, 32'd1000, 32'd33, res, lat);
        tests_run++;
        if (res !== 32'd10 || lat !== 35) begin tests_failed++; $display("FAIL b2b_second: got %h lat %0d want 0000000a lat 35", res, lat); end
        @(posedge clk_i); #1;
        tests_run++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin tests_failed++; $display("FAIL valid_one_cycle: valid %b busy %b want 0 0", valid_o, busy_o); end
        repeat (3) @(posedge clk_i);
        #1;
        tests_run++;
        if (result_o !== 32'd10) begin tests_failed++; $display("FAIL result_hold: got %h want 0000000a", result_o); end
    endtask

    task automatic test_stall();
        int got = -1;
        ops_i = DIV_U; op_A_i = 32'd100; op_B_i = 32'd7; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        tests_run++;
        if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL busy_after_accept: got %b want 1", busy_o); end
        for (int n = 1; n <= 80; n++) begin
            clk_en_i = !(n >= 6 && n <= 15);
            kill_i   = (n == 8);
            valid_i  = (n == 3);
            if (n == 3) begin ops_i = DIVU_U; op_A_i = 32'd200; op_B_i = 32'd3; end
            @(posedge clk_i); #1;
            if (valid_o) begin got = n; break; end
        end
        clk_en_i = 1'b1; kill_i = 1'b0; valid_i = 1'b0;
        tests_run++;
        if (got !== 45) begin tests_failed++; $display("FAIL stall_latency: got %0d want 45", got); end
        tests_run++;
        if (result_o !== 32'd14) begin tests_failed++; $display("FAIL stall_result: got %h want 0000000e", result_o); end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL busy_at_valid: got %b want 0", busy_o); end
        clk_en_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        tests_run++;
        if (valid_o !== 1'b1) begin tests_failed++; $display("FAIL valid_held_in_stall: got %b want 1", valid_o); end
        clk_en_i = 1'b1;
        @(posedge clk_i); #1;
        tests_run++;
        if (valid_o !== 1'b0 || result_o !== 32'd14) begin
            tests_failed++; $display("FAIL valid_after_stall: valid %b result %h want 0 0000000e", valid_o, result_o);
        end
    endtask

    task automatic test_kill();
        data_u res; int lat; logic saw = 1'b0;
        ops_i = DIV_U; op_A_i = 32'd100; op_B_i = 32'd7; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            kill_i = (n == 10);
            @(posedge clk_i); #1;
            if (valid_o) saw = 1'b1;
        end
        kill_i = 1'b0;
        tests_run++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || saw !== 1'b0) begin
            tests_failed++; $display("FAIL kill_state: busy %b valid %b saw_valid %b want 0 0 0", busy_o, valid_o, saw);
        end
        tests_run++;
        if (result_o !== 32'd14) begin tests_failed++; $display("FAIL kill_result_kept: got %h want 0000000e", result_o); end
        run_op(DIVU_U, 32'd1000, 32'd33, res, lat);
        tests_run++;
        if (res !== 32'd30 || lat !== 35) begin tests_failed++; $display("FAIL after_kill: got %h lat %0d want 0000001e lat 35", res, lat); end
        kill_i = 1'b1; valid_i = 1'b1; ops_i = DIVU_U; op_A_i = 32'd5; op_B_i = 32'd0;
        @(posedge clk_i); #1;
        kill_i = 1'b0; valid_i = 1'b0; saw = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk_i); #1;
            if (valid_o || busy_o) saw = 1'b1;
        end
        tests_run++;
        if (saw !== 1'b0) begin tests_failed++; $display("FAIL kill_over_valid: got activity %b want 0", saw); end
    endtask

    task automatic test_async_reset();
        data_u res; int lat; logic saw = 1'b0;
        ops_i = REMU_U; op_A_i = 32'd1000; op_B_i = 32'd33; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        tests_run++;
        if (result_o !== 32'h0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset: result %h valid %b busy %b want 00000000 0 0", result_o, valid_o, busy_o);
        end
        repeat (2) begin
            @(posedge clk_i); #1;
            if (valid_o || busy_o) saw = 1'b1;
        end
        tests_run++;
        if (saw !== 1'b0) begin tests_failed++; $display("FAIL activity_in_reset: got %b want 0", saw); end
        @(negedge clk_i); rst_n_i = 1'b1;
        run_op(DIV_U, 32'd100, 32'd7, res, lat);
        tests_run++;
        if (res !== 32'd14 || lat !== 35) begin tests_failed++; $display("FAIL first_after_reset: got %h lat %0d want 0000000e lat 35", res, lat); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_back_to_back();
        test_stall();
        test_kill();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mgt_01_div_unit.md
MGT_01_DIV_UNIT -- requirements
Module: MGT_01_div_unit

Interface
REQ-001 Parameters: none; the unit SHALL take XLEN (32) from the shared package.
REQ-002 clk_i  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 clk_en_i  in  1  pipeline stall; when low, all state and outputs SHALL hold.
REQ-005 kill_i  in  1  flush; aborts any in-flight division.
REQ-006 valid_i  in  1  request strobe; sampled only when busy_o is low.
REQ-007 op_A_i  in  XLEN (data_u)  dividend.
REQ-008 op_B_i  in  XLEN (data_u)  divisor.
REQ-009 ops_i  in  div_ops_e  DIV_U, DIVU_U, REM_U or REMU_U; sampled with valid_i.
REQ-010 result_o  out  XLEN (data_u)  registered quotient or remainder.
REQ-011 valid_o  out  1  result_o valid; high for exactly one enabled cycle.
REQ-012 busy_o  out  1  high from the accept edge until the edge that asserts valid_o.

Function
REQ-013 Accept: an enabled edge with state IDLE, valid_i=1 and kill_i=0 SHALL latch operands and ops_i (edge E0).
REQ-014 FSM states: IDLE, PREPARE, DIVIDE, RESTORE, DONE.
- IDLE->PREPARE on accept.
- PREPARE->DIVIDE, or PREPARE->DONE on a special case.
- DIVIDE->RESTORE after 32 iterations.
- RESTORE->DONE.
- DONE->IDLE.
REQ-015 PREPARE: signed ops SHALL take absolute values and record quotient sign (A xor B) and remainder sign (A); unsigned ops SHALL use operands as-is.
REQ-016 DIVIDE: radix-2 restoring, one quotient bit per enabled cycle, 6-bit iteration counter, XLEN+1-bit partial-remainder subtractor.
REQ-017 RESTORE: negate quotient/remainder per recorded signs, then select by ops_i.
REQ-018 Normal latency: valid_o SHALL rise at E35 (counting enabled edges only).
REQ-019 Divide by zero: quotient SHALL be 0xFFFFFFFF and remainder SHALL be the dividend, for both signed and unsigned ops; valid_o SHALL rise at E2.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV_U/REM_U): quotient SHALL be 0x80000000 and remainder SHALL be 0; valid_o SHALL rise at E2.
REQ-021 result_o SHALL hold its last value until the next valid_o.
REQ-022 valid_i while busy_o=1 SHALL be ignored; no queuing.
REQ-023 A valid_i in the DONE cycle SHALL be ignored; acceptance is possible again from the IDLE cycle after valid_o.
REQ-024 kill_i=1 on an enabled edge SHALL force IDLE and deassert valid_o/busy_o; result_o is unchanged; kill_i has priority over valid_i.
REQ-025 clk_en_i=0 SHALL freeze the counter and FSM, with valid_o held and kill_i ignored.

Reset
REQ-026 rst_n_i low SHALL immediately force IDLE with valid_o=0, busy_o=0, result_o=0 and counter=0, including mid-operation.
REQ-027 The first accept SHALL be possible on the first enabled edge after rst_n_i deasserts.

Structure
REQ-028 The shared package SHALL hold div_ops_e (beside mul_ops_e), the div_fsm_e state enum, and the DIV_ITER=32 constant.
REQ-029 One sub-module SHALL be used: MGT_01_div_step, a combinational single restoring iteration (shift, subtract, quotient bit); there SHALL be no vendor IP.

Verification
REQ-030 DIV_U 100/7 -> 14 (0x0000000E) at E35; REM_U 100/7 -> 2.
REQ-031 DIV_U -100/7 -> 0xFFFFFFF2; REM_U -100/7 -> 0xFFFFFFFE; DIVU_U 0xFFFFFFFF/2 -> 0x7FFFFFFF.
REQ-032 DIVU_U 5/0 -> 0xFFFFFFFF; REMU_U 5/0 -> 5; DIV_U -5/0 -> 0xFFFFFFFF; all with valid_o at E2.
REQ-033 DIV_U 0x80000000/0xFFFFFFFF -> 0x80000000; REM_U -> 0; valid_o at E2.
REQ-034 DIV_U 100/7 with clk_en_i low for 10 cycles during DIVIDE -> valid_o 10 cycles later, result 14; valid_i pulsed while busy -> ignored.
REQ-035 kill_i at E10 -> IDLE, no valid_o, immediate new request accepted; rst_n_i low at E20 of another op -> outputs 0 asynchronously, no valid_o.
